// File: rtl/ex_stage.sv
`timescale 1ns/1ps
// ============================================================================
// ex_stage -- pipeline execute stage
//
// Sits directly behind the ID/EX register. Selects forwarded operands, runs
// the single-cycle ALU operations, owns the HI/LO pair and an iterative
// 32-step multiply/divide unit, and registers the result into the EX/MEM
// outputs.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               bubble EX/MEM and abort any running mult/div
//   pc_plus4, instr     from ID/EX; instr[15:11]=rd, [20:16]=rt, [10:6]=shamt
//   rd1, rd2, ext       register operands and extended immediate
//   alusrc, regdst      B = ext when alusrc; destination = rd when regdst
//   aluctrl             operation code (0..19 defined, 20..31 give 0)
//   memr/memw/mem2r/regw  control bits travelling to EX/MEM
//   fwd_a, fwd_b        0/3: register file, 1: exmem_alu_res, 2: wb_data
//   wb_data             MEM/WB write-back value
//   md_stall            combinational, high while a mult/div holds EX
//   exmem_*             registered EX/MEM outputs
// ============================================================================
module ex_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] ext,
    input  logic        alusrc,
    input  logic        regdst,
    input  logic [4:0]  aluctrl,
    input  logic        memr,
    input  logic        memw,
    input  logic        mem2r,
    input  logic        regw,
    input  logic [1:0]  fwd_a,
    input  logic [1:0]  fwd_b,
    input  logic [31:0] wb_data,
    output logic        md_stall,
    output logic [31:0] exmem_alu_res,
    output logic [31:0] exmem_wdata,
    output logic [31:0] exmem_pc_plus4,
    output logic [4:0]  exmem_rd,
    output logic        exmem_memr,
    output logic        exmem_memw,
    output logic        exmem_mem2r,
    output logic        exmem_regw
);

    localparam logic [4:0] LAST_CNT = 5'(MD_CYCLES - 1);

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_XOR  = 5'd4;
    localparam logic [4:0] OP_NOR  = 5'd5;
    localparam logic [4:0] OP_SLT  = 5'd6;
    localparam logic [4:0] OP_SLTU = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SRL  = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_LUI  = 5'd11;
    localparam logic [4:0] OP_MFHI = 5'd16;
    localparam logic [4:0] OP_MFLO = 5'd17;
    localparam logic [4:0] OP_MTHI = 5'd18;
    localparam logic [4:0] OP_MTLO = 5'd19;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_BUSY,
        MD_DONE
    } md_state_t;

    md_state_t   state_reg, state_next;
    logic [4:0]  count_reg, count_next;

    // Iteration datapath. acc_reg is {partial product, multiplier} for a
    // multiply and {remainder, quotient} for a divide; dsr_reg holds the
    // multiplicand or the divisor magnitude.
    logic [63:0] acc_reg;
    logic [31:0] dsr_reg;
    logic [31:0] dividend_reg;
    logic        is_div_reg;
    logic        neg_lo_reg;
    logic        neg_hi_reg;
    logic        div0_reg;
    logic [31:0] hi_reg, lo_reg;

    logic [31:0] op_a, op_bf, op_b;
    logic [31:0] alu_res;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        is_md;
    logic        md_done;

    // Bits of instr that this stage has no use for.
    logic unused_instr;
    assign unused_instr = ^{instr[31:21], instr[5:0]};

    assign shamt   = instr[10:6];
    assign dest    = regdst ? instr[15:11] : instr[20:16];
    assign is_md   = (aluctrl[4:2] == 3'b011);          // codes 12..15
    assign md_done = (state_reg == MD_DONE);
    assign md_stall = is_md && !md_done;

    // ------------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------------
    always_comb begin
        case (fwd_a)
            2'd1:    op_a = exmem_alu_res;
            2'd2:    op_a = wb_data;
            default: op_a = rd1;
        endcase
        case (fwd_b)
            2'd1:    op_bf = exmem_alu_res;
            2'd2:    op_bf = wb_data;
            default: op_bf = rd2;
        endcase
        op_b = alusrc ? ext : op_bf;
    end

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    always_comb begin
        alu_res = 32'd0;
        case (aluctrl)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLTU: alu_res = {31'd0, op_a < op_b};
            OP_SLL:  alu_res = op_b << shamt;
            OP_SRL:  alu_res = op_b >> shamt;
            OP_SRA:  alu_res = $signed(op_b) >>> shamt;
            OP_LUI:  alu_res = {op_b[15:0], 16'h0000};
            OP_MFHI: alu_res = hi_reg;
            OP_MFLO: alu_res = lo_reg;
            default: alu_res = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Mult/div operand preparation (used only when leaving IDLE)
    // Even codes (12 MULT, 14 DIV) are signed, bit 1 selects divide.
    // ------------------------------------------------------------------
    logic        md_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;

    assign md_signed = ~aluctrl[0];
    assign a_neg     = md_signed & op_a[31];
    assign b_neg     = md_signed & op_b[31];
    assign a_mag     = a_neg ? (32'd0 - op_a) : op_a;
    assign b_mag     = b_neg ? (32'd0 - op_b) : op_b;

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] step_res;
    logic [63:0] prod_fix;
    logic [31:0] hi_fin, lo_fin;

    always_comb begin
        // Shift-add: conditionally add the multiplicand into the upper half,
        // then shift the whole product/multiplier pair right by one.
        mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, dsr_reg} : 33'd0);
        mul_next = {mul_sum, acc_reg[31:1]};

        // Restoring divide: shift next dividend bit into the remainder and
        // keep the subtraction only when it does not go negative.
        div_shift = acc_reg[63:31];
        div_diff  = {1'b0, div_shift} - {2'b00, dsr_reg};
        if (div_diff[33])
            div_next = {div_shift[31:0], acc_reg[30:0], 1'b0};
        else
            div_next = {div_diff[31:0], acc_reg[30:0], 1'b1};

        step_res = is_div_reg ? div_next : mul_next;
        prod_fix = neg_lo_reg ? (64'd0 - step_res) : step_res;

        if (!is_div_reg) begin
            hi_fin = prod_fix[63:32];
            lo_fin = prod_fix[31:0];
        end else if (div0_reg) begin
            hi_fin = dividend_reg;
            lo_fin = 32'hFFFF_FFFF;
        end else begin
            lo_fin = neg_lo_reg ? (32'd0 - step_res[31:0])  : step_res[31:0];
            hi_fin = neg_hi_reg ? (32'd0 - step_res[63:32]) : step_res[63:32];
        end
    end

    // ------------------------------------------------------------------
    // Mult/div FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        if (flush) begin
            state_next = MD_IDLE;
            count_next = 5'd0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (is_md) begin
                        state_next = MD_BUSY;
                        count_next = 5'd0;
                    end
                end
                MD_BUSY: begin
                    count_next = count_reg + 5'd1;
                    if (count_reg == LAST_CNT) begin
                        state_next = MD_DONE;
                        count_next = 5'd0;
                    end
                end
                MD_DONE: state_next = MD_IDLE;
                default: state_next = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= MD_IDLE;
            count_reg <= 5'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Iteration registers and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg      <= 64'd0;
            dsr_reg      <= 32'd0;
            dividend_reg <= 32'd0;
            is_div_reg   <= 1'b0;
            neg_lo_reg   <= 1'b0;
            neg_hi_reg   <= 1'b0;
            div0_reg     <= 1'b0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
        end else if (!flush) begin
            if (state_reg == MD_IDLE && is_md) begin
                acc_reg      <= {32'd0, a_mag};
                dsr_reg      <= b_mag;
                dividend_reg <= op_a;
                is_div_reg   <= aluctrl[1];
                neg_lo_reg   <= a_neg ^ b_neg;
                neg_hi_reg   <= a_neg;
                div0_reg     <= aluctrl[1] && (op_b == 32'd0);
            end else if (state_reg == MD_BUSY) begin
                acc_reg <= step_res;
            end

            if (state_reg == MD_BUSY && count_reg == LAST_CNT) begin
                hi_reg <= hi_fin;
                lo_reg <= lo_fin;
            end else if (aluctrl == OP_MTHI) begin
                hi_reg <= op_a;
            end else if (aluctrl == OP_MTLO) begin
                lo_reg <= op_a;
            end
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exmem_alu_res  <= 32'd0;
            exmem_wdata    <= 32'd0;
            exmem_pc_plus4 <= 32'd0;
            exmem_rd       <= 5'd0;
            exmem_memr     <= 1'b0;
            exmem_memw     <= 1'b0;
            exmem_mem2r    <= 1'b0;
            exmem_regw     <= 1'b0;
        end else if (flush || md_stall) begin
            exmem_alu_res  <= 32'd0;
            exmem_wdata    <= 32'd0;
            exmem_pc_plus4 <= 32'd0;
            exmem_rd       <= 5'd0;
            exmem_memr     <= 1'b0;
            exmem_memw     <= 1'b0;
            exmem_mem2r    <= 1'b0;
            exmem_regw     <= 1'b0;
        end else begin
            // A retiring mult/div writes only HI/LO, never the register
            // file or memory.
            exmem_alu_res  <= alu_res;
            exmem_wdata    <= op_bf;
            exmem_pc_plus4 <= pc_plus4;
            exmem_rd       <= dest;
            exmem_memr     <= memr & ~md_done;
            exmem_memw     <= memw & ~md_done;
            exmem_mem2r    <= mem2r;
            exmem_regw     <= regw & ~md_done;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush;
    logic [31:0] pc_plus4, instr, rd1, rd2, ext, wb_data;
    logic        alusrc, regdst, memr, memw, mem2r, regw;
    logic [4:0]  aluctrl;
    logic [1:0]  fwd_a, fwd_b;
    logic        md_stall;
    logic [31:0] exmem_alu_res, exmem_wdata, exmem_pc_plus4;
    logic [4:0]  exmem_rd;
    logic        exmem_memr, exmem_memw, exmem_mem2r, exmem_regw;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .pc_plus4(pc_plus4), .instr(instr), .rd1(rd1), .rd2(rd2), .ext(ext),
        .alusrc(alusrc), .regdst(regdst), .aluctrl(aluctrl),
        .memr(memr), .memw(memw), .mem2r(mem2r), .regw(regw),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data),
        .md_stall(md_stall),
        .exmem_alu_res(exmem_alu_res), .exmem_wdata(exmem_wdata),
        .exmem_pc_plus4(exmem_pc_plus4), .exmem_rd(exmem_rd),
        .exmem_memr(exmem_memr), .exmem_memw(exmem_memw),
        .exmem_mem2r(exmem_mem2r), .exmem_regw(exmem_regw)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [3:0]  ctl;   // {regw, memr, memw, mem2r}
    } exp_t;

    exp_t sb_q[$];
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = ~(a | b);
            5'd6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd7:  r = (a < b) ? 32'd1 : 32'd0;
            5'd8:  r = b << sh;
            5'd9:  r = b >> sh;
            5'd10: r = $signed(b) >>> sh;
            5'd11: r = {b[15:0], 16'h0000};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Returns {HI, LO}
    function automatic logic [63:0] md_ref(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = 64'd0;
        case (op)
            5'd12: res = sa * sb;
            5'd13: res = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 5'd14) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {32'(ua % ub), 32'(ua / ub)};
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] mk_instr(input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [4:0] sh);
        return {11'd0, rt, rd, sh, 6'd0};
    endfunction

    task automatic set_nop();
        flush   = 1'b0;
        instr   = 32'd0;
        rd1     = 32'd0;
        rd2     = 32'd0;
        ext     = 32'd0;
        alusrc  = 1'b0;
        regdst  = 1'b1;
        aluctrl = 5'd0;
        memr    = 1'b0;
        memw    = 1'b0;
        mem2r   = 1'b0;
        regw    = 1'b0;
        fwd_a   = 2'd0;
        fwd_b   = 2'd0;
        wb_data = 32'd0;
    endtask

    // Push the expected EX/MEM contents for the instruction now on the
    // inputs, clock it, then pop and compare what the DUT registered.
    task automatic exec(input string tag, input logic [31:0] exp_alu,
                        input logic [31:0] exp_wd, input logic [4:0] exp_rd);
        exp_t e;
        e.alu   = exp_alu;
        e.wdata = exp_wd;
        e.pc    = pc_plus4;
        e.rd    = exp_rd;
        e.ctl   = {regw, memr, memw, mem2r};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, "/alu_res"}, exmem_alu_res, e.alu);
        chk({tag, "/wdata"}, exmem_wdata, e.wdata);
        chk({tag, "/pc"}, exmem_pc_plus4, e.pc);
        chk({tag, "/rd"}, {27'd0, exmem_rd}, {27'd0, e.rd});
        chk({tag, "/ctl"}, {28'd0, exmem_regw, exmem_memr, exmem_memw, exmem_mem2r},
            {28'd0, e.ctl});
        $display("txn %s: alu_res=%h wdata=%h rd=%0d ctl=%b", tag, exmem_alu_res,
                 exmem_wdata, exmem_rd, {exmem_regw, exmem_memr, exmem_memw, exmem_mem2r});
        pc_plus4 = pc_plus4 + 32'd4;
    endtask

    task automatic read_hilo(input string tag);
        set_nop();
        aluctrl = 5'd17;
        regw    = 1'b1;
        rd2     = 32'h77;
        instr   = mk_instr(5'd0, 5'd10, 5'd0);
        exec({tag, "/mflo"}, exp_lo, 32'h77, 5'd10);
        set_nop();
        aluctrl = 5'd16;
        regw    = 1'b1;
        rd2     = 32'h66;
        instr   = mk_instr(5'd0, 5'd11, 5'd0);
        exec({tag, "/mfhi"}, exp_hi, 32'h66, 5'd11);
    endtask

    task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want_hi,
                          input logic [31:0] want_lo);
        int stall_n;
        int bub_bad;
        set_nop();
        aluctrl = op;
        rd1     = a;
        rd2     = b;
        regw    = 1'b1;
        memr    = 1'b1;
        memw    = 1'b1;
        instr   = mk_instr(5'd0, 5'd9, 5'd0);
        pc_plus4 = pc_plus4 + 32'd4;
        #1;
        stall_n = 0;
        bub_bad = 0;
        while (md_stall === 1'b1 && stall_n < 60) begin
            stall_n++;
            @(posedge clk);
            #1;
            if ({exmem_regw, exmem_memr, exmem_memw, exmem_mem2r} !== 4'd0 ||
                exmem_alu_res !== 32'd0 || exmem_pc_plus4 !== 32'd0)
                bub_bad++;
        end
        chk({tag, "/stall_len"}, stall_n, 33);
        chk({tag, "/bubbles"}, bub_bad, 0);
        @(posedge clk);
        #1;
        chk({tag, "/done_ctl"}, {29'd0, exmem_regw, exmem_memr, exmem_memw}, 32'd0);
        $display("txn %s: op=%0d a=%h b=%h stall=%0d", tag, op, a, b, stall_n);
        exp_hi = want_hi;
        exp_lo = want_lo;
        read_hilo(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, bv;
        logic [4:0]  rop, rsh, rrd, rrt;
        logic [63:0] md;

        // ---------------- reset ----------------
        set_nop();
        regw     = 1'b1;
        memw     = 1'b1;
        rd1      = 32'h5;
        pc_plus4 = 32'h100;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/alu_res", exmem_alu_res, 32'd0);
        chk("rst/pc", exmem_pc_plus4, 32'd0);
        chk("rst/wdata", exmem_wdata, 32'd0);
        chk("rst/ctl_rd", {23'd0, exmem_rd, exmem_regw, exmem_memr, exmem_memw, exmem_mem2r},
            32'd0);
        set_nop();
        pc_plus4 = 32'd0;
        rst_n = 1'b1;
        #1;
        chk("rel/ctl", {28'd0, exmem_regw, exmem_memr, exmem_memw, exmem_mem2r}, 32'd0);
        chk("rel/md_stall", {31'd0, md_stall}, 32'd0);

        // ---------------- ADD ----------------
        set_nop();
        rd1 = 32'd5; rd2 = 32'd7; regw = 1'b1;
        instr = mk_instr(5'd0, 5'd3, 5'd0);
        exec("add", 32'd12, 32'd7, 5'd3);

        // ---------------- forwarding ----------------
        set_nop();
        rd1 = 32'h10; regw = 1'b1; regdst = 1'b0;
        instr = mk_instr(5'd4, 5'd0, 5'd0);
        exec("add10", 32'h10, 32'd0, 5'd4);
        set_nop();
        aluctrl = 5'd1; fwd_a = 2'd1; rd1 = 32'hDEAD; alusrc = 1'b1; ext = 32'd4;
        rd2 = 32'h55; regw = 1'b1; instr = mk_instr(5'd0, 5'd5, 5'd0);
        exec("sub_fwda", 32'h0C, 32'h55, 5'd5);
        set_nop();
        fwd_b = 2'd2; wb_data = 32'hAA; rd2 = 32'h1; memw = 1'b1;
        rd1 = 32'h100; alusrc = 1'b1; ext = 32'd8;
        exec("st_fwdb", 32'h108, 32'hAA, 5'd0);
        set_nop();
        fwd_a = 2'd2; wb_data = 32'h30; rd1 = 32'h1; rd2 = 32'h3; regw = 1'b1; mem2r = 1'b1;
        instr = mk_instr(5'd0, 5'd6, 5'd0);
        exec("add_fwda_wb", 32'h33, 32'h3, 5'd6);

        // ---------------- random single-cycle ops ----------------
        for (int i = 0; i < 24; i++) begin
            rop = (i % 6 == 5) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 11));
            ra  = $urandom;
            rb  = $urandom;
            rsh = 5'($urandom);
            rrd = 5'($urandom);
            rrt = 5'($urandom);
            set_nop();
            aluctrl = rop;
            rd1     = ra;
            rd2     = rb;
            alusrc  = 1'($urandom_range(0, 1));
            ext     = $urandom;
            regdst  = 1'($urandom_range(0, 1));
            instr   = {11'($urandom), rrt, rrd, rsh, 6'($urandom)};
            regw    = 1'b1;
            fwd_a   = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
            fwd_b   = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
            bv      = alusrc ? ext : rb;
            exec($sformatf("alu%0d_op%0d", i, rop), alu_ref(rop, ra, bv, rsh), rb,
                 regdst ? rrd : rrt);
        end

        // ---------------- mult / div ----------------
        run_md("mult_m2x3", 5'd12, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("div_m7d2", 5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu_9d0", 5'd15, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
        run_md("div_ovf", 5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_md("div_m9d0", 5'd14, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) begin
            rop = 5'(12 + i);
            ra  = $urandom;
            rb  = (i >= 2) ? 32'($urandom_range(1, 70000)) : $urandom;
            md  = md_ref(rop, ra, rb);
            run_md($sformatf("md_rand%0d", i), rop, ra, rb, md[63:32], md[31:0]);
        end

        // ---------------- flush mid-BUSY ----------------
        set_nop();
        aluctrl = 5'd12; rd1 = 32'd5; rd2 = 32'd6; regw = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush/ctl", {28'd0, exmem_regw, exmem_memr, exmem_memw, exmem_mem2r}, 32'd0);
        chk("flush/alu_res", exmem_alu_res, 32'd0);
        set_nop();
        #1;
        chk("flush/md_stall", {31'd0, md_stall}, 32'd0);
        $display("txn flush: aborted MULT at count 10");
        read_hilo("flush_keep");
        run_md("multu_3x4", 5'd13, 32'd3, 32'd4, 32'd0, 32'd12);

        // ---------------- MTHI / MTLO then MFHI / MFLO ----------------
        set_nop();
        aluctrl = 5'd18; rd1 = 32'h1234;
        @(posedge clk);
        #1;
        $display("txn mthi: A=%h", 32'h1234);
        exp_hi = 32'h1234;
        set_nop();
        aluctrl = 5'd16; regw = 1'b1; instr = mk_instr(5'd0, 5'd12, 5'd0);
        exec("mfhi_b2b", 32'h1234, 32'd0, 5'd12);
        set_nop();
        aluctrl = 5'd19; fwd_a = 2'd2; wb_data = 32'h5678;
        @(posedge clk);
        #1;
        $display("txn mtlo: A=%h", 32'h5678);
        exp_lo = 32'h5678;
        read_hilo("mt_back");

        // ---------------- async reset mid-BUSY ----------------
        set_nop();
        aluctrl = 5'd12; rd1 = 32'd7; rd2 = 32'd9; regw = 1'b1;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst/alu_res", exmem_alu_res, 32'd0);
        chk("arst/ctl_rd", {23'd0, exmem_rd, exmem_regw, exmem_memr, exmem_memw, exmem_mem2r},
            32'd0);
        chk("arst/pc_wdata", exmem_pc_plus4 | exmem_wdata, 32'd0);
        set_nop();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("arst/md_stall", {31'd0, md_stall}, 32'd0);
        $display("txn reset: pulsed mid-BUSY");
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        read_hilo("arst_hilo");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
